// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM driving the relPrime multicycle datapath strobes
module multicycle_control #(
  parameter int OPW = 4,
  parameter int SW  = 5
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [OPW-1:0] Opcode,
  input  logic           Zero,
  output logic           PCWrite,
  output logic           PCWriteCond,
  output logic           BranchNE,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           RegWrite,
  output logic           ALUSrcA,
  output logic [1:0]     MemtoReg,
  output logic [1:0]     RegDst,
  output logic [1:0]     ALUSrcB,
  output logic [2:0]     ALUOp,
  output logic [1:0]     PCSource,
  output logic [SW-1:0]  current_state,
  output logic [SW-1:0]  next_state,
  output logic           Halted
);
  typedef enum logic [SW-1:0] {
    FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5,
    R_EXEC = 6, R_WB = 7, BRANCH = 8, JUMP = 9, I_EXEC = 10, I_WB = 11,
    JAL = 12, JR = 13, HALT = 14
  } state_t;
  localparam logic [OPW-1:0] OP_R = 0, OP_ADDI = 1, OP_LW = 2, OP_SW = 3, OP_BEQ = 4,
    OP_BNE = 5, OP_J = 6, OP_JAL = 7, OP_JR = 8, OP_ORI = 9, OP_HALT = 15;
  state_t state, nxt;
  logic unused_zero;
  assign unused_zero = Zero;
  assign current_state = state;
  assign next_state = nxt;
  always_ff @(posedge CLK)
    state <= nxt;
  always_comb begin
    nxt = FETCH;
    if (RST_N)
      case (state)
        FETCH: nxt = DECODE;
        DECODE:
          case (Opcode)
            OP_LW, OP_SW:    nxt = MEM_ADDR;
            OP_R:            nxt = R_EXEC;
            OP_BEQ, OP_BNE:  nxt = BRANCH;
            OP_J:            nxt = JUMP;
            OP_ADDI, OP_ORI: nxt = I_EXEC;
            OP_JAL:          nxt = JAL;
            OP_JR:           nxt = JR;
            OP_HALT:         nxt = HALT;
            default:         nxt = FETCH;
          endcase
        MEM_ADDR: nxt = Opcode == OP_LW ? MEM_READ : MEM_WRITE;
        MEM_READ: nxt = MEM_WB;
        R_EXEC:   nxt = R_WB;
        I_EXEC:   nxt = I_WB;
        HALT:     nxt = HALT;
        default:  nxt = FETCH;
      endcase
  end
  always_comb begin
    PCWrite = 1'b0;
    PCWriteCond = 1'b0;
    IorD = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA = 1'b0;
    MemtoReg = 2'd0;
    RegDst = 2'd0;
    ALUSrcB = 2'd0;
    ALUOp = 3'b000;
    PCSource = 2'd0;
    Halted = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'd1;
      end
      DECODE: ALUSrcB = 2'd3;
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD = 1'b1;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'd1;
      end
      MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD = 1'b1;
      end
      R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp = 3'b010;
      end
      R_WB: begin
        RegWrite = 1'b1;
        RegDst = 2'd1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp = 3'b001;
        PCWriteCond = 1'b1;
        PCSource = 2'd1;
      end
      JUMP: begin
        PCWrite = 1'b1;
        PCSource = 2'd2;
      end
      I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        ALUOp = Opcode == OP_ORI ? 3'b011 : 3'b000;
      end
      I_WB: RegWrite = 1'b1;
      JAL: begin
        RegWrite = 1'b1;
        RegDst = 2'd2;
        MemtoReg = 2'd2;
        PCWrite = 1'b1;
        PCSource = 2'd2;
      end
      JR: begin
        PCWrite = 1'b1;
        PCSource = 2'd3;
      end
      HALT: Halted = 1'b1;
      default: ;
    endcase
  end
  // IR is held outside FETCH, so Opcode is stable while BRANCH is active
  assign BranchNE = state == BRANCH && Opcode == OP_BNE;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed vectors against hand-computed state sequences and strobes
module tb_multicycle_control;
  logic CLK = 1'b0, RST_N = 1'b0, Zero = 1'b0;
  logic [3:0] Opcode = 4'd0;
  logic PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, Halted;
  logic [1:0] MemtoReg, RegDst, ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [4:0] current_state, next_state;
  int n_cmp = 0, n_bad = 0;
  multicycle_control dut (
    .CLK(CLK), .RST_N(RST_N), .Opcode(Opcode), .Zero(Zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .current_state(current_state),
    .next_state(next_state), .Halted(Halted)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge CLK);
    #1;
  endtask
  task automatic expect_state(input string tag, input int exp);
    step();
    check(tag, 32'(current_state), 32'(exp));
  endtask
  initial begin
    step();
    step();
    check("rst_state", 32'(current_state), 0);
    check("rst_next", 32'(next_state), 0);
    check("rst_memread", 32'(MemRead), 1);
    check("rst_irwrite", 32'(IRWrite), 1);
    check("rst_pcwrite", 32'(PCWrite), 1);
    check("rst_alusrcb", 32'(ALUSrcB), 1);
    RST_N = 1'b1;
    Opcode = 4'd0;
    #1;
    check("fetch_next", 32'(next_state), 1);
    expect_state("r_decode", 1);
    check("decode_alusrcb", 32'(ALUSrcB), 3);
    check("decode_next_r", 32'(next_state), 6);
    expect_state("r_exec", 6);
    check("r_exec_aluop", 32'(ALUOp), 2);
    expect_state("r_wb", 7);
    check("r_wb_regdst", 32'(RegDst), 1);
    check("r_wb_regwrite", 32'(RegWrite), 1);
    RST_N = 1'b0;
    #1;
    check("rst7_next", 32'(next_state), 0);
    expect_state("rst7_state", 0);
    RST_N = 1'b1;
    Opcode = 4'd2;
    begin
      int seq[5] = '{1, 2, 3, 4, 0};
      for (int i = 0; i < 5; i++) begin
        expect_state($sformatf("lw_s%0d", i), seq[i]);
        check($sformatf("lw_regwrite%0d", i), 32'(RegWrite), seq[i] == 4 ? 1 : 0);
        check($sformatf("lw_memtoreg%0d", i), 32'(MemtoReg), seq[i] == 4 ? 1 : 0);
      end
    end
    Opcode = 4'd3;
    expect_state("sw_decode", 1);
    expect_state("sw_addr", 2);
    check("sw_addr_alusrcb", 32'(ALUSrcB), 2);
    expect_state("sw_write", 5);
    check("sw_memwrite", 32'(MemWrite), 1);
    check("sw_iord", 32'(IorD), 1);
    expect_state("sw_done", 0);
    Opcode = 4'd4;
    expect_state("beq_decode", 1);
    expect_state("beq_branch", 8);
    check("beq_pcwc", 32'(PCWriteCond), 1);
    check("beq_bne", 32'(BranchNE), 0);
    check("beq_pcsrc", 32'(PCSource), 1);
    check("beq_aluop", 32'(ALUOp), 1);
    expect_state("beq_done", 0);
    Opcode = 4'd5;
    expect_state("bne_decode", 1);
    check("bne_decode_bne", 32'(BranchNE), 0);
    expect_state("bne_branch", 8);
    check("bne_bne", 32'(BranchNE), 1);
    expect_state("bne_done", 0);
    Opcode = 4'd7;
    expect_state("jal_decode", 1);
    expect_state("jal_state", 12);
    check("jal_regdst", 32'(RegDst), 2);
    check("jal_memtoreg", 32'(MemtoReg), 2);
    check("jal_pcwrite", 32'(PCWrite), 1);
    check("jal_pcsrc", 32'(PCSource), 2);
    expect_state("jal_done", 0);
    Opcode = 4'd6;
    expect_state("j_decode", 1);
    expect_state("j_state", 9);
    check("j_pcsrc", 32'(PCSource), 2);
    expect_state("j_done", 0);
    Opcode = 4'd8;
    expect_state("jr_decode", 1);
    expect_state("jr_state", 13);
    check("jr_pcsrc", 32'(PCSource), 3);
    expect_state("jr_done", 0);
    Opcode = 4'd9;
    expect_state("ori_decode", 1);
    expect_state("ori_exec", 10);
    check("ori_aluop", 32'(ALUOp), 3);
    expect_state("ori_wb", 11);
    check("ori_wb_regwrite", 32'(RegWrite), 1);
    expect_state("ori_done", 0);
    Opcode = 4'd1;
    expect_state("addi_decode", 1);
    expect_state("addi_exec", 10);
    check("addi_aluop", 32'(ALUOp), 0);
    Opcode = 4'd11;
    expect_state("addi_wb", 11);
    expect_state("addi_done", 0);
    expect_state("ill_decode", 1);
    check("ill_regwrite", 32'(RegWrite), 0);
    check("ill_memwrite", 32'(MemWrite), 0);
    expect_state("ill_done", 0);
    Opcode = 4'd15;
    expect_state("halt_decode", 1);
    expect_state("halt_s0", 14);
    check("halt_flag", 32'(Halted), 1);
    check("halt_pcwrite", 32'(PCWrite), 0);
    expect_state("halt_s1", 14);
    expect_state("halt_s2", 14);
    RST_N = 1'b0;
    expect_state("halt_rst", 0);
    check("halt_rst_flag", 32'(Halted), 0);
    RST_N = 1'b1;
    Opcode = 4'd2;
    expect_state("mid_decode", 1);
    expect_state("mid_addr", 2);
    expect_state("mid_read", 3);
    check("mid_read_memread", 32'(MemRead), 1);
    check("mid_read_regwrite", 32'(RegWrite), 0);
    RST_N = 1'b0;
    expect_state("mid_rst", 0);
    check("mid_rst_regwrite", 32'(RegWrite), 0);
    RST_N = 1'b1;
    expect_state("mid_after", 1);
    check("mid_after_regwrite", 32'(RegWrite), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
